hack_data_mem: RTL and testbench
================================

HACK_DATA_MEM -- requirements
Module: hack_data_mem

Interface
REQ-001 The block SHALL have exactly these parameters, one per line as name, default, meaning:
- RAM_WORDS, 16384, general RAM depth
- SCR_WORDS, 8192, screen memory depth
REQ-002 The block SHALL have exactly these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock, all state updates on its rising edge
- reset  input  1  synchronous, active-low reset
- addressM  input  15  CPU data address
- outM  input  16  CPU write data
- writeM  input  1  CPU write enable
- inM  output  16  read data to the CPU
- kbd_valid  input  1  key code offered
- kbd_code  input  16  key code
- kbd_ready  output  1  key code accepted this cycle
- kbd_release  input  1  key released pulse
- scan_en  input  1  screen scan enable
- scan_word  output  16  scanned screen word
- scan_addr  output  13  screen index of scan_word
- scan_valid  output  1  scan_word/scan_addr valid
- frame_start  output  1  scan_word is screen word 0

Function
REQ-003 The address map SHALL be: 0x0000-0x3FFF RAM, 0x4000-0x5FFF screen, 0x6000 keyboard register KBD, 0x6001-0x7FFF unmapped.
REQ-004 inM SHALL be a combinational read of the current addressM with zero-cycle latency, matching the CPU's same-cycle inM expectation.
REQ-005 When writeM=1, outM SHALL be written on the rising edge to the addressed RAM or screen word; the new value SHALL appear on inM from the next cycle.
REQ-006 Writes to KBD or to unmapped addresses SHALL be ignored; reads of unmapped addresses SHALL return 0x0000.
REQ-007 A read of KBD SHALL return the KBD register.
REQ-008 kbd_ready SHALL be 1 in every cycle where reset is deasserted; a cycle with kbd_valid=1 and kbd_ready=1 SHALL load kbd_code into KBD.
REQ-009 kbd_release=1 SHALL clear KBD to 0x0000 on the next edge; if kbd_valid and kbd_release are both 1 in the same cycle, kbd_valid SHALL win.
REQ-010 The scan counter SHALL advance by 1 per cycle while scan_en=1, SHALL wrap from SCR_WORDS-1 to 0, and SHALL hold while scan_en=0.
REQ-011 The scan read SHALL be synchronous with 1-cycle latency: scan_word, scan_addr and scan_valid SHALL reflect the counter value from the previous cycle; scan_valid SHALL be 0 in the cycle after a cycle with scan_en=0.
REQ-012 frame_start SHALL be 1 exactly when scan_valid=1 and scan_addr=0.
REQ-013 If a CPU write and a scan read hit the same screen word in the same cycle, the scan port SHALL return the old data (read-before-write).

Reset
REQ-014 While reset=0 at a rising edge, the block SHALL clear KBD to 0, clear the scan counter to 0, and drive scan_valid=0, frame_start=0, scan_word=0, scan_addr=0 and kbd_ready=0.
REQ-015 Reset SHALL NOT clear RAM or screen contents; CPU writes are ignored during reset.
REQ-016 Reset asserted mid-scan SHALL restart the scan at word 0 on the first enabled cycle after release.

Structure
REQ-017 The region base addresses (0x0000, 0x4000, 0x6000), depths and width constants SHALL live in a shared package hack_mem_pkg.
REQ-018 The screen array and its scan counter/output pipeline SHALL form one sub-module, hack_screen_scan; RAM, decoding and KBD SHALL stay in the top.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write 0x1234 to address 0x0010, then read address 0x0010 -> inM=0x1234 one cycle after the write.
- Write 0xFFFF to address 0x4000 with scan_en=1 from reset -> first scan_valid has scan_addr=0, scan_word=0xFFFF, frame_start=1.
- kbd_valid=1 with code 0x0041, then read address 0x6000 -> 0x0041; kbd_release then read again -> 0x0000; valid and release in the same cycle with code 0x0042 -> 0x0042.
- Write 0xBEEF to address 0x6000 or 0x7000 -> KBD unchanged, and a read of 0x7000 returns 0x0000.
- Scan for 8193 enabled cycles -> scan_addr goes 8191 then 0 with frame_start=1; deassert scan_en for 3 cycles -> scan_valid=0 and scan_addr holds.
- Same-cycle CPU write of 0xAAAA and scan read of screen word 5 (old value 0x5555) -> scan_word=0x5555; reset low mid-scan -> all outputs 0 and the scan restarts at 0.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared address map, widths and region decoding for the Hack data memory.
package hack_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int RAM_AW = 14;
    localparam int SCR_AW = 13;

    localparam logic [ADDR_W-1:0] RAM_BASE = 15'h0000;
    localparam logic [ADDR_W-1:0] SCR_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_BASE = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_e;

    // Everything above the single KBD word is unmapped.
    function automatic region_e decodeRegion(input logic [ADDR_W-1:0] addr);
        if (addr < SCR_BASE) begin
            return REG_RAM;
        end else if (addr < KBD_BASE) begin
            return REG_SCR;
        end else if (addr == KBD_BASE) begin
            return REG_KBD;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_screen_scan.sv
// Screen memory with a CPU port and a free-running raster scan port (1-cycle read latency).
module hack_screen_scan
    import hack_mem_pkg::*;
#(
    parameter int SCR_WORDS = 8192
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_we_i,
    input  logic [SCR_AW-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              scan_en_i,
    output logic [DATA_W-1:0] scan_word_o,
    output logic [SCR_AW-1:0] scan_addr_o,
    output logic              scan_valid_o,
    output logic              frame_start_o
);

    localparam logic [SCR_AW-1:0] LAST_IDX = SCR_AW'(SCR_WORDS - 1);

    logic [DATA_W-1:0] scr [SCR_WORDS];

    logic [SCR_AW-1:0] cnt_q, cnt_d;
    logic [SCR_AW-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] word_q;

    // Contents survive reset; the write port is gated by the parent.
    always_ff @(posedge clk_i) begin
        if (cpu_we_i) begin
            scr[cpu_addr_i] <= cpu_wdata_i;
        end
    end

    assign cpu_rdata_o = scr[cpu_addr_i];

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        if (scan_en_i) begin
            cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            addr_d  = cnt_q;
            valid_d = 1'b1;
        end
    end

    // Non-blocking read of scr gives old data when the CPU writes the same word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            if (scan_en_i) begin
                word_q <= scr[cnt_q];
            end
        end
    end

    assign scan_word_o   = word_q;
    assign scan_addr_o   = addr_q;
    assign scan_valid_o  = valid_q;
    assign frame_start_o = valid_q && (addr_q == '0);

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data memory: RAM, memory-mapped screen with scan-out, and keyboard register.
module hack_data_mem
    import hack_mem_pkg::*;
#(
    parameter int RAM_WORDS = 16384,
    parameter int SCR_WORDS = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addressM,
    input  logic [DATA_W-1:0] outM,
    input  logic              writeM,
    output logic [DATA_W-1:0] inM,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_code,
    output logic              kbd_ready,
    input  logic              kbd_release,
    input  logic              scan_en,
    output logic [DATA_W-1:0] scan_word,
    output logic [SCR_AW-1:0] scan_addr,
    output logic              scan_valid,
    output logic              frame_start
);

    logic [DATA_W-1:0] ram [RAM_WORDS];

    region_e           region;
    logic [RAM_AW-1:0] ramIdx;
    logic [SCR_AW-1:0] scrIdx;
    logic [DATA_W-1:0] scrRdata;
    logic              scrWe;
    logic [DATA_W-1:0] kbd_q, kbd_d;

    assign region = decodeRegion(addressM);
    assign ramIdx = RAM_AW'(addressM - RAM_BASE);
    assign scrIdx = SCR_AW'(addressM - SCR_BASE);
    assign scrWe  = reset && writeM && (region == REG_SCR);

    always_ff @(posedge clk) begin
        if (reset && writeM && (region == REG_RAM)) begin
            ram[ramIdx] <= outM;
        end
    end

    // A new key code takes priority over a release in the same cycle.
    always_comb begin
        kbd_d = kbd_q;
        if (kbd_valid) begin
            kbd_d = kbd_code;
        end else if (kbd_release) begin
            kbd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            kbd_q <= '0;
        end else begin
            kbd_q <= kbd_d;
        end
    end

    assign kbd_ready = reset;

    always_comb begin
        inM = '0;
        case (region)
            REG_RAM:  inM = ram[ramIdx];
            REG_SCR:  inM = scrRdata;
            REG_KBD:  inM = kbd_q;
            default:  inM = '0;
        endcase
    end

    hack_screen_scan #(
        .SCR_WORDS(SCR_WORDS)
    ) uScreen (
        .clk_i        (clk),
        .rst_ni       (reset),
        .cpu_we_i     (scrWe),
        .cpu_addr_i   (scrIdx),
        .cpu_wdata_i  (outM),
        .cpu_rdata_o  (scrRdata),
        .scan_en_i    (scan_en),
        .scan_word_o  (scan_word),
        .scan_addr_o  (scan_addr),
        .scan_valid_o (scan_valid),
        .frame_start_o(frame_start)
    );

endmodule

// File: tb/tb_hack_data_mem.sv
// Self-checking bench for hack_data_mem: per-cycle model comparison plus directed literal checks.
module tb_hack_data_mem;

    localparam int RAM_WORDS = 16384;
    localparam int SCR_WORDS = 8192;

    logic        clk;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
    logic        kbd_release;
    logic        scan_en;
    logic [15:0] scan_word;
    logic [12:0] scan_addr;
    logic        scan_valid;
    logic        frame_start;

    int total;
    int bad;

    hack_data_mem #(
        .RAM_WORDS(RAM_WORDS),
        .SCR_WORDS(SCR_WORDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addressM   (addressM),
        .outM       (outM),
        .writeM     (writeM),
        .inM        (inM),
        .kbd_valid  (kbd_valid),
        .kbd_code   (kbd_code),
        .kbd_ready  (kbd_ready),
        .kbd_release(kbd_release),
        .scan_en    (scan_en),
        .scan_word  (scan_word),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain arrays and integer arithmetic
    logic [15:0] mRam   [RAM_WORDS];
    bit          mRamWr [RAM_WORDS];
    logic [15:0] mScr   [SCR_WORDS];
    bit          mScrWr [SCR_WORDS];
    logic [15:0] mKbd;
    int          mCnt;
    bit          mValid;
    int          mAddr;
    logic [15:0] mWord;
    bit          mWordKnown;
    bit          started;

    initial begin
        started    = 1'b0;
        mKbd       = 16'h0;
        mCnt       = 0;
        mValid     = 1'b0;
        mAddr      = 0;
        mWord      = 16'h0;
        mWordKnown = 1'b1;
        for (int i = 0; i < RAM_WORDS; i++) mRamWr[i] = 1'b0;
        for (int i = 0; i < SCR_WORDS; i++) mScrWr[i] = 1'b0;
    end

    always @(posedge clk) begin
        int a;
        a = int'(addressM);
        if (!reset) begin
            mKbd       = 16'h0;
            mCnt       = 0;
            mValid     = 1'b0;
            mAddr      = 0;
            mWord      = 16'h0;
            mWordKnown = 1'b1;
        end else begin
            // the scan sees memory as it was before this cycle's write
            if (scan_en) begin
                mWord      = mScr[mCnt];
                mWordKnown = mScrWr[mCnt];
                mAddr      = mCnt;
                mValid     = 1'b1;
                mCnt       = (mCnt + 1) % SCR_WORDS;
            end else begin
                mValid = 1'b0;
            end
            if (writeM) begin
                if (a < 'h4000) begin
                    mRam[a]   = outM;
                    mRamWr[a] = 1'b1;
                end else if (a < 'h6000) begin
                    mScr[a - 'h4000]   = outM;
                    mScrWr[a - 'h4000] = 1'b1;
                end
            end
            if (kbd_valid) mKbd = kbd_code;
            else if (kbd_release) mKbd = 16'h0;
        end
        started = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on every falling edge once the model has seen an edge
    always @(negedge clk) begin
        int a;
        if (started) begin
            a = int'(addressM);
            if (a < 'h4000) begin
                if (mRamWr[a]) checkOutput("m_inM_ram", 32'(inM), 32'(mRam[a]));
            end else if (a < 'h6000) begin
                if (mScrWr[a - 'h4000]) checkOutput("m_inM_scr", 32'(inM), 32'(mScr[a - 'h4000]));
            end else if (a == 'h6000) begin
                checkOutput("m_inM_kbd", 32'(inM), 32'(mKbd));
            end else begin
                checkOutput("m_inM_unmapped", 32'(inM), 32'h0);
            end
            checkOutput("m_kbd_ready", 32'(kbd_ready), 32'(reset));
            checkOutput("m_scan_valid", 32'(scan_valid), 32'(mValid));
            checkOutput("m_scan_addr", 32'(scan_addr), 32'(mAddr));
            checkOutput("m_frame_start", 32'(frame_start), 32'(mValid && (mAddr == 0)));
            if (mWordKnown) checkOutput("m_scan_word", 32'(scan_word), 32'(mWord));
        end
    end

    // Drive one cycle's inputs, let one rising edge pass, return 1 time unit after it
    task automatic applyStimulus(input logic rst, input logic [14:0] addr, input logic [15:0] data,
                                 input logic we, input logic se, input logic kv,
                                 input logic [15:0] kc, input logic kr);
        reset       = rst;
        addressM    = addr;
        outM        = data;
        writeM      = we;
        scan_en     = se;
        kbd_valid   = kv;
        kbd_code    = kc;
        kbd_release = kr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        addressM    = 15'h6000;
        outM        = 16'h0;
        writeM      = 1'b0;
        scan_en     = 1'b0;
        kbd_valid   = 1'b0;
        kbd_code    = 16'h0;
        kbd_release = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_kbd_ready", 32'(kbd_ready), 32'h0);
        checkOutput("rst_scan_valid", 32'(scan_valid), 32'h0);
        checkOutput("rst_scan_word", 32'(scan_word), 32'h0);
        checkOutput("rst_scan_addr", 32'(scan_addr), 32'h0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
        checkOutput("rst_kbd_reg", 32'(inM), 32'h0);

        // Screen word 0 written, then the first scan returns it
        applyStimulus(1'b1, 15'h4000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("scr0_inM", 32'(inM), 32'hFFFF);
        checkOutput("ready_after_rst", 32'(kbd_ready), 32'h1);
        applyStimulus(1'b1, 15'h4000, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("first_scan_valid", 32'(scan_valid), 32'h1);
        checkOutput("first_scan_addr", 32'(scan_addr), 32'h0);
        checkOutput("first_scan_word", 32'(scan_word), 32'hFFFF);
        checkOutput("first_frame_start", 32'(frame_start), 32'h1);

        // RAM write then read
        applyStimulus(1'b1, 15'h0010, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("ram_rd_0010", 32'(inM), 32'h1234);
        checkOutput("scan_off_valid", 32'(scan_valid), 32'h0);

        // Keyboard load, release, and valid-beats-release
        applyStimulus(1'b1, 15'h6000, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0041, 1'b0);
        checkOutput("kbd_load_41", 32'(inM), 32'h0041);
        applyStimulus(1'b1, 15'h6000, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("kbd_release", 32'(inM), 32'h0000);
        applyStimulus(1'b1, 15'h6000, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b1);
        checkOutput("kbd_valid_wins", 32'(inM), 32'h0042);

        // Writes to KBD and unmapped space are ignored
        applyStimulus(1'b1, 15'h6000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("kbd_write_ignored", 32'(inM), 32'h0042);
        applyStimulus(1'b1, 15'h7000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("unmapped_rd_7000", 32'(inM), 32'h0000);
        applyStimulus(1'b1, 15'h6000, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("kbd_after_unmapped", 32'(inM), 32'h0042);

        // Scan counter sits at 1; run a full frame plus one word to see the wrap
        for (int i = 0; i < SCR_WORDS; i++) begin
            applyStimulus(1'b1, 15'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            if (i == SCR_WORDS - 2) begin
                checkOutput("wrap_last_addr", 32'(scan_addr), 32'd8191);
                checkOutput("wrap_last_frame", 32'(frame_start), 32'h0);
            end
            if (i == SCR_WORDS - 1) begin
                checkOutput("wrap_zero_addr", 32'(scan_addr), 32'd0);
                checkOutput("wrap_zero_frame", 32'(frame_start), 32'h1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 15'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            checkOutput("hold_valid", 32'(scan_valid), 32'h0);
            checkOutput("hold_addr", 32'(scan_addr), 32'd0);
        end

        // Read-before-write on screen word 5 (counter now at 1)
        applyStimulus(1'b1, 15'h4005, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (4) applyStimulus(1'b1, 15'h4005, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 15'h4005, 16'hAAAA, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("rbw_scan_addr", 32'(scan_addr), 32'd5);
        checkOutput("rbw_scan_word", 32'(scan_word), 32'h5555);
        checkOutput("rbw_cpu_new", 32'(inM), 32'hAAAA);

        // Reset mid-scan: outputs clear, memory kept, writes and keys ignored
        applyStimulus(1'b1, 15'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("pre_rst_addr", 32'(scan_addr), 32'd6);
        applyStimulus(1'b0, 15'h0010, 16'h9999, 1'b1, 1'b1, 1'b1, 16'h0077, 1'b0);
        checkOutput("mid_rst_valid", 32'(scan_valid), 32'h0);
        checkOutput("mid_rst_addr", 32'(scan_addr), 32'h0);
        checkOutput("mid_rst_word", 32'(scan_word), 32'h0);
        checkOutput("mid_rst_frame", 32'(frame_start), 32'h0);
        checkOutput("mid_rst_ready", 32'(kbd_ready), 32'h0);
        checkOutput("rst_write_ignored", 32'(inM), 32'h1234);
        applyStimulus(1'b0, 15'h6000, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("rst_kbd_cleared", 32'(inM), 32'h0);
        applyStimulus(1'b1, 15'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("restart_valid", 32'(scan_valid), 32'h1);
        checkOutput("restart_addr", 32'(scan_addr), 32'd0);
        checkOutput("restart_frame", 32'(frame_start), 32'h1);
        checkOutput("restart_word", 32'(scan_word), 32'hFFFF);
        applyStimulus(1'b1, 15'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
